game_ctrl: RTL
==============

Name: game_ctrl

Overview:
- Game-phase sequencer that sits directly downstream of the crash checker and the bean/score logic.
- Consumes the ghost-crash flag, the all-beans-eaten flag, the running score and a start request.
- Produces:
  - the run enable that gates pacman/ghost motion;
  - the latched game-over and win flags that Display consumes;
  - a lives count, a respawn pulse and a persistent high score for the seven-segment display.
- Replaces the ad-hoc sticky game-over register at top level with a proper lives/respawn flow.

Parameters:
- LIVES, 3: lives loaded at game start (1..3; lives output is 2 bits).
- READY_TICKS, 120: frame ticks spent in READY before play resumes (1..255).
- DEATH_TICKS, 60: frame ticks spent in DYING animation (1..255).

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- tick  in  1  one-cycle frame strobe (one pulse per VGA frame)
- start  in  1  one-cycle start/restart request from keypad or PS2
- ghost_hit  in  1  level; pacman overlaps any ghost
- beans_clear  in  1  level; every bean eaten
- score  in  9  current score from bean logic
- phase  out  3  0 IDLE, 1 READY, 2 PLAY, 3 DYING, 4 OVER, 5 WIN, 6 PAUSED
- run_en  out  1  high only in PLAY
- respawn  out  1  one-cycle pulse: pacman/ghosts return to home positions
- new_game  out  1  one-cycle pulse: beans and score reload
- lives  out  2  remaining lives
- over  out  1  high in OVER
- win  out  1  high in WIN
- high_score  out  9  best score since reset

Behaviour:
- Reset (clrn low, async) forces the following, all registered:
  - phase=IDLE, tick counter=0, lives=LIVES, high_score=0;
  - run_en=0, respawn=0, new_game=0, over=0, win=0.
- Reset mid-game aborts immediately; no pulses are emitted.
- All outputs are registered; a state change is visible 1 cycle after the qualifying input edge.
- IDLE:
  - start -> READY; lives<=LIVES; new_game and respawn each pulse 1 cycle.
- READY:
  - 8-bit counter clears on entry and increments on tick.
  - When a tick arrives with counter==READY_TICKS-1 -> PLAY.
  - ghost_hit and beans_clear are ignored.
- PLAY:
  - run_en=1.
  - beans_clear=1 -> WIN; beans_clear has priority when both beans_clear and ghost_hit are high in the same cycle.
  - Else ghost_hit=1 -> DYING; lives decrements by 1 on that transition and saturates at 0.
- DYING:
  - run_en=0; counter clears on entry.
  - On the DEATH_TICKS-th tick:
    - lives==0 -> OVER;
    - else -> READY with a 1-cycle respawn pulse.
- OVER / WIN:
  - over or win held high; run_en=0.
  - high_score<=score on entry when score>high_score (unsigned 9-bit compare; equal does not update).
  - start -> READY with lives<=LIVES, new_game and respawn pulses; over/win drop on the same edge.
- start in READY, PLAY or DYING is ignored.
- tick and start arriving in the same cycle as a state entry do not count toward the new state.
- ghost_hit is level-sensitive, but a hit remaining high across READY does not cost a life until PLAY is re-entered with ghost_hit still high. That is intended, since respawn separates the sprites.
- phase encoding 7 is unreachable; if it is ever entered, the block returns to IDLE on the next clock.

Optional Feature:
- Macro GAME_CTRL_PAUSE_EN.
- When defined:
  - an extra input `pause` (1-bit, one-cycle pulse) is added;
  - pause in PLAY -> PAUSED (run_en=0, counter frozen, lives unchanged);
  - pause in PAUSED -> PLAY;
  - in PAUSED, ghost_hit and beans_clear are ignored and start is ignored.
- When undefined:
  - there is no pause port;
  - PAUSED is unreachable and the phase value 6 is treated like 7.

Test Plan:
1. Reset, start pulse, then 120 ticks -> new_game and respawn pulse on the cycle after start; phase=READY through tick 119; phase=PLAY and run_en=1 one cycle after tick 120.
2. In PLAY, hold ghost_hit 1 cycle with LIVES=3 -> phase=DYING, lives=2, run_en=0. After 60 ticks: respawn pulse and phase=READY.
3. Three successive hits -> after the third DYING: phase=OVER, over=1, lives=0. With score=57 and high_score=0 -> high_score=57. A start pulse -> READY, lives=3, over=0.
4. In PLAY, assert ghost_hit and beans_clear in the same cycle with score=120 -> phase=WIN, win=1, lives unchanged, high_score=120.
5. Second game ending in OVER with score=40 after high_score=57 -> high_score stays 57. Pull clrn low mid-DYING -> all outputs at reset values immediately, high_score=0.
6. With GAME_CTRL_PAUSE_EN: pause in PLAY -> PAUSED, run_en=0. ghost_hit while paused -> no change. A second pause -> PLAY, run_en=1.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: game-phase sequencer for the pacman top level.
// Tracks lives, drives run enable, respawn/new-game pulses, latches the
// game-over / win flags and keeps the best score seen since reset.
// Optional build macro GAME_CTRL_PAUSE_EN adds a `pause` input and the PAUSED phase.
module game_ctrl #(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned READY_TICKS = 120,
  parameter int unsigned DEATH_TICKS = 60
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tick,
  input  logic       start,
  input  logic       ghost_hit,
  input  logic       beans_clear,
  input  logic [8:0] score,
`ifdef GAME_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] phase,
  output logic       run_en,
  output logic       respawn,
  output logic       new_game,
  output logic [1:0] lives,
  output logic       over,
  output logic       win,
  output logic [8:0] high_score
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReady  = 3'd1,
    StPlay   = 3'd2,
    StDying  = 3'd3,
    StOver   = 3'd4,
    StWin    = 3'd5,
    StPaused = 3'd6
  } phase_e;

  localparam logic [1:0] LivesInit = 2'(LIVES);
  localparam logic [7:0] ReadyLast = 8'(READY_TICKS - 1);
  localparam logic [7:0] DeathLast = 8'(DEATH_TICKS - 1);

  phase_e     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lives_q, lives_d;
  logic [8:0] high_score_q, high_score_d;
  logic       run_en_q, run_en_d;
  logic       respawn_q, respawn_d;
  logic       new_game_q, new_game_d;
  logic       over_q, over_d;
  logic       win_q, win_d;
  logic       load_game;
  logic       respawn_req;
  logic       entering_end;

  // State and registered outputs; reset aborts any game in progress.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      phase_q      <= StIdle;
      cnt_q        <= 8'd0;
      lives_q      <= LivesInit;
      high_score_q <= 9'd0;
      run_en_q     <= 1'b0;
      respawn_q    <= 1'b0;
      new_game_q   <= 1'b0;
      over_q       <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      lives_q      <= lives_d;
      high_score_q <= high_score_d;
      run_en_q     <= run_en_d;
      respawn_q    <= respawn_d;
      new_game_q   <= new_game_d;
      over_q       <= over_d;
      win_q        <= win_d;
    end
  end

  // Next phase, lives bookkeeping and pulse requests.
  always_comb begin
    phase_d     = phase_q;
    lives_d     = lives_q;
    load_game   = 1'b0;
    respawn_req = 1'b0;
    case (phase_q)
      StIdle, StOver, StWin: begin
        if (start) begin
          phase_d   = StReady;
          lives_d   = LivesInit;
          load_game = 1'b1;
        end
      end
      StReady: begin
        if (tick && (cnt_q == ReadyLast)) phase_d = StPlay;
      end
      StPlay: begin
        // Clearing the board wins even if a ghost touches on the same cycle.
        if (beans_clear) begin
          phase_d = StWin;
        end else if (ghost_hit) begin
          phase_d = StDying;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (pause) begin
          phase_d = StPaused;
        end
`endif
      end
      StDying: begin
        if (tick && (cnt_q == DeathLast)) begin
          if (lives_q == 2'd0) begin
            phase_d = StOver;
          end else begin
            phase_d     = StReady;
            respawn_req = 1'b1;
          end
        end
      end
`ifdef GAME_CTRL_PAUSE_EN
      StPaused: begin
        if (pause) phase_d = StPlay;
      end
`endif
      default: phase_d = StIdle;
    endcase
  end

  // Frame-tick counter: cleared on every phase change so an entry-cycle tick never counts.
  always_comb begin
    cnt_d = cnt_q;
    if (phase_d != phase_q) begin
      cnt_d = 8'd0;
    end else if (tick && ((phase_q == StReady) || (phase_q == StDying))) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Next values of the registered outputs, decoded from the upcoming phase.
  always_comb begin
    run_en_d     = (phase_d == StPlay);
    over_d       = (phase_d == StOver);
    win_d        = (phase_d == StWin);
    new_game_d   = load_game;
    respawn_d    = load_game | respawn_req;
    entering_end = ((phase_d == StOver) || (phase_d == StWin)) && (phase_d != phase_q);
    high_score_d = high_score_q;
    if (entering_end && (score > high_score_q)) high_score_d = score;
  end

  assign phase      = phase_q;
  assign run_en     = run_en_q;
  assign respawn    = respawn_q;
  assign new_game   = new_game_q;
  assign lives      = lives_q;
  assign over       = over_q;
  assign win        = win_q;
  assign high_score = high_score_q;

endmodule
